// File: rtl/scroll_text_7seg_pkg.sv
// Shared types and active-low 7-segment font for the scrolling text driver.
// Segment order is bit0=a .. bit6=g; a 0 lights the segment.
package scroll_text_7seg_pkg;

  typedef enum logic {IDLE, SCROLL} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [0:9][6:0] FONT_DIGIT = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Letters A..Z; lowercase shares these glyphs.
  localparam logic [0:25][6:0] FONT_ALPHA = {
    7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h79, 7'h61,
    7'h0A, 7'h47, 7'h2A, 7'h2B, 7'h40, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07,
    7'h41, 7'h63, 7'h15, 7'h36, 7'h11, 7'h24
  };

endpackage

// File: rtl/seg_font_decode.sv
// Combinational ASCII to active-low 7-segment glyph; unmapped codes are blank.
module seg_font_decode
  import scroll_text_7seg_pkg::*;
(
  input  logic [7:0] ch,
  output logic [6:0] seg
);

  logic [4:0] alpha_idx;

  always_comb begin
    seg       = SEG_BLANK;
    alpha_idx = ch[4:0] - 5'd1;
    if (ch[7:4] == 4'h3 && ch[3:0] <= 4'd9) begin
      seg = FONT_DIGIT[ch[3:0]];
    end else if ((ch[7:5] == 3'b010 || ch[7:5] == 3'b011) &&
                 ch[4:0] >= 5'd1 && ch[4:0] <= 5'd26) begin
      seg = FONT_ALPHA[alpha_idx];
    end
  end

endmodule

// File: rtl/scroll_text_7seg.sv
// Scrolling message driver for NUM_DIGITS active-low 7-segment digits.
// Define SCROLL_LOOP_EN to repeat passes continuously instead of a single pass.
module scroll_text_7seg
  import scroll_text_7seg_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int MSG_DEPTH  = 16,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [7:0]              WrChar,
  input  logic                    WrValid,
  output logic                    WrReady,
  input  logic                    Clear,
  input  logic                    Start,
  input  logic                    Stop,
  output logic                    Busy,
  output logic                    Done,
  output logic [NUM_DIGITS*7-1:0] HexSeg
);

  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int PW = $clog2(MSG_DEPTH + 2 * NUM_DIGITS + 1);
  localparam int JW = PW + 1;
  localparam int DW = $clog2(SCROLL_DIV);
  localparam logic [LW-1:0] DEPTH_L  = LW'(MSG_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCROLL_DIV - 1);

  state_t          state, state_next;
  logic [LW-1:0]   len, len_next;
  logic [PW-1:0]   pos, pos_next;
  logic [PW-1:0]   end_pos;
  logic [DW-1:0]   div, div_next;
  logic            write_en;
  logic            show;
  logic [7:0]      msg_buf [MSG_DEPTH];
  logic [NUM_DIGITS*7-1:0] dig_flat;

  assign WrReady  = (state == IDLE) && !Clear && (len < DEPTH_L);
  assign write_en = WrValid && WrReady;
  assign Busy     = (state == SCROLL);
  assign end_pos  = PW'(len) + PW'(NUM_DIGITS);

  always_comb begin
    state_next = state;
    len_next   = len;
    pos_next   = pos;
    div_next   = div;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Clear) begin
          len_next = '0;
        end else if (write_en) begin
          len_next = len + LW'(1);
        end
        // Start looks at the post-write length so a same-cycle character is included.
        if (Start && len_next != '0) begin
          state_next = SCROLL;
          pos_next   = '0;
          div_next   = '0;
        end
      end
      SCROLL: begin
        if (Stop) begin
          state_next = IDLE;
          pos_next   = '0;
          div_next   = '0;
        end else if (div == DIV_LAST) begin
          div_next = '0;
          if (pos + PW'(1) == end_pos) begin
            Done = 1'b1;
`ifdef SCROLL_LOOP_EN
            pos_next = '0;
`else
            state_next = IDLE;
            pos_next   = '0;
`endif
          end else begin
            pos_next = pos + PW'(1);
          end
        end else begin
          div_next = div + DW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Display is blanked on the cycle that leaves SCROLL so IDLE never shows stale text.
  assign show = (state == SCROLL) && (state_next == SCROLL);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state  <= IDLE;
      len    <= '0;
      pos    <= '0;
      div    <= '0;
      HexSeg <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state  <= state_next;
      len    <= len_next;
      pos    <= pos_next;
      div    <= div_next;
      HexSeg <= show ? dig_flat : {NUM_DIGITS{SEG_BLANK}};
    end
  end

  always_ff @(posedge Clock) begin
    if (write_en) begin
      msg_buf[len[AW-1:0]] <= WrChar;
    end
  end

  // Stream position j: NUM_DIGITS leading blanks, then the message, then trailing blanks.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [JW-1:0] j;
    logic [AW-1:0] rel;
    logic [7:0]    ch;
    logic [6:0]    seg;

    always_comb begin
      j   = JW'(pos) + JW'(NUM_DIGITS - 1 - k);
      rel = AW'(j - JW'(NUM_DIGITS));
      ch  = 8'h20;
      if (j >= JW'(NUM_DIGITS) && j < JW'(NUM_DIGITS) + JW'(len)) begin
        ch = msg_buf[rel];
      end
    end

    seg_font_decode u_decode (
      .ch  (ch),
      .seg (seg)
    );

    assign dig_flat[7*k +: 7] = seg;
  end

endmodule

// File: doc/scroll_text_7seg.md
Name: scroll_text_7seg

Overview:
- Parametrised scrolling-message driver for a bank of NUM_DIGITS active-low 7-segment digits.
- A producer writes ASCII characters into an internal buffer over a valid/ready port. On Start, the text scrolls right-to-left across the digits at a programmable rate.
- Sits between control logic (buttons/CPU) and the board HEX pins; successor to the static per-digit ASCII decoders.

Parameters:
- NUM_DIGITS, 5, number of 7-segment digits driven.
- MSG_DEPTH, 16, maximum message length in characters.
- SCROLL_DIV, 25000000, Clock cycles per scroll step (minimum 2).

Ports:
- Clock  in  1  system clock; all logic rising-edge.
- Resetn  in  1  synchronous, active-low reset.
- WrChar  in  8  ASCII character to append.
- WrValid  in  1  WrChar valid.
- WrReady  out  1  buffer accepts a character this cycle.
- Clear  in  1  empties buffer (IDLE only).
- Start  in  1  begin scrolling.
- Stop  in  1  abort scrolling.
- Busy  out  1  high in SCROLL state.
- Done  out  1  one-cycle pulse at end of each pass.
- HexSeg  out  NUM_DIGITS*7  segments; digit k at [7k+6:7k], k=NUM_DIGITS-1 leftmost; bit0=a..bit6=g; 0 = segment lit.

Behaviour:
- Reset (Resetn=0 at a Clock edge): state IDLE, len=0, pos=0, divider=0, Busy=0, Done=0, HexSeg all ones (blank).
- States:
  - IDLE: display blank.
    - Write accepted when WrValid && WrReady: buf[len]<=WrChar, len++.
    - WrReady = (state==IDLE) && !Clear && (len<MSG_DEPTH).
    - Clear sets len=0; Clear wins over a same-cycle write.
    - Start with resulting len>0 → SCROLL next cycle, pos=0, divider=0.
    - Start with len==0 is ignored.
    - A write and Start in the same cycle: the character is stored and included in the scroll.
  - SCROLL: Busy=1, WrReady=0, Clear ignored.
    - divider counts 0..SCROLL_DIV-1. At SCROLL_DIV-1, divider wraps to 0 and pos increments.
- Virtual stream index j:
  - j<NUM_DIGITS → blank.
  - NUM_DIGITS≤j<NUM_DIGITS+len → buf[j-NUM_DIGITS].
  - otherwise → blank.
- Digit k shows stream[pos + (NUM_DIGITS-1-k)]. Text enters at the right digit and exits at the left.
- End of pass: the step where pos would reach len+NUM_DIGITS. Done pulses in that same cycle. Outcome depends on SCROLL_LOOP_EN (see below).
- Stop in SCROLL → IDLE next cycle, display blank, no Done. Stop wins over Start.
- Buffer contents and len are retained across passes and Stop; only Clear or reset empties the buffer.
- HexSeg is registered: it reflects pos one cycle after pos changes (entry into SCROLL shows all blank, since pos=0).
- pos width: $clog2(MSG_DEPTH+2*NUM_DIGITS+1). No arithmetic overflow is permitted.
- Font (via decoder), active-low 7-bit:
  - '0'=7'h40, '1'=7'h79, '8'=7'h00.
  - 'H'/'h'=7'h09, 'A'/'a'=7'h08. Letters are case-insensitive.
  - Space, blank, and any unmapped code = 7'h7F.
- Reset mid-scroll: returns to the reset state in one cycle; the buffer is emptied.

Optional Feature:
- Macro: SCROLL_LOOP_EN.
- Defined: at end of pass, pos wraps to 0 and scrolling continues. Done pulses every pass; Busy stays 1 until Stop or reset.
- Undefined: single pass. At end of pass, state → IDLE and Busy=0 next cycle; display blank.

Decomposition:
- Package scroll_text_7seg_pkg:
  - state enum {IDLE, SCROLL};
  - SEG_BLANK=7'h7F;
  - font constants for digits 0-9 and letters A-Z.
- Sub-module seg_font_decode: combinational ASCII[7:0] → seg[6:0] using the package constants.
- One instance per digit; the top instantiates NUM_DIGITS copies under generate.

Test Plan (NUM_DIGITS=5, MSG_DEPTH=8, SCROLL_DIV=4):
- Reset: Resetn=0 for 2 cycles → HexSeg=35'h7FFFFFFFF, Busy=0, WrReady=1, Done=0.
- Fill: write "H","A","1" then Start → Busy=1 next cycle.
  - After 4 cycles, rightmost digit=7'h09, others 7'h7F.
  - After 12 cycles, digits[2:0]=09,08,79.
- Pass end (loop undefined): 3-char message → Done pulses once 32 cycles after Start (8 steps×4). Busy=0 next cycle; HexSeg all 7'h7F.
- Full/backpressure: 8 writes → WrReady=0. A 9th WrValid is dropped, len stays 8.
  - Clear with concurrent WrValid → len=0, write dropped.
- Stop/Start collision: in SCROLL assert Start&&Stop → IDLE next cycle, no Done. Start with len=0 → stays IDLE.
- Loop (SCROLL_LOOP_EN): message "8" → Done every 24 cycles (6 steps×4) for 3 passes, Busy held 1. Mid-scroll Resetn=0 → reset state, len=0.
